// File: rtl/p2s_arb_ctrl.sv
// Two-requester arbiter and sequencer that shares one p2s serialiser between channels 0 and 1.
// Define P2S_ARB_CTRL_PRIO_EN for fixed priority (channel 0 wins); default build is round-robin.
module p2s_arb_ctrl #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             p2s_rst,
   output logic             p2s_load,
   output logic [WIDTH-1:0] p2s_par,
   output logic             ser_valid,
   output logic             ser_chan,
   output logic             frame_done,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             chan_q, chan_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             p2s_rst_q, p2s_rst_d;
   logic             p2s_load_q, p2s_load_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_chan_q, ser_chan_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;
   logic             gnt_chan_s;
   logic             accept_s;

`ifndef P2S_ARB_CTRL_PRIO_EN
   logic             last_grant_q, last_grant_d;
`endif

   // Grant selection: contested requests go to the channel that did not win last time.
   always_comb begin
      gnt_chan_s = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef P2S_ARB_CTRL_PRIO_EN
         gnt_chan_s = 1'b0;
`else
         gnt_chan_s = ~last_grant_q;
`endif
      end else if (req1_valid) begin
         gnt_chan_s = 1'b1;
      end else begin
         gnt_chan_s = 1'b0;
      end
   end

   // Ready only while idle and the serialiser is out of its clear.
   assign accept_s   = (state_q == S_IDLE) && !p2s_rst_q && (req0_valid || req1_valid);
   assign req0_ready = accept_s && !gnt_chan_s;
   assign req1_ready = accept_s && gnt_chan_s;

`ifndef P2S_ARB_CTRL_PRIO_EN
   // Remember the last winner for round-robin.
   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_s) begin
         last_grant_d = gnt_chan_s;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Last-grant register; resets to 1 so channel 0 wins the first contest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Frame sequencer next-state and registered-output values.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      chan_d    = chan_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      p2s_rst_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               data_d  = gnt_chan_s ? req1_data : req0_data;
               chan_d  = gnt_chan_s;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            bit_cnt_d = BIT_LAST;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            if (bit_cnt_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = GAP_LAST;
                  state_d   = S_GAP;
               end else begin
                  state_d   = S_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - CW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d   = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // serout lags the serialiser's shift by one edge, so the strobes are one cycle behind SHIFT
      p2s_load_d   = (state_d == S_LOAD);
      busy_d       = (state_d != S_IDLE);
      ser_valid_d  = (state_q == S_SHIFT);
      ser_chan_d   = chan_q;
      frame_done_d = (state_q == S_SHIFT) && (bit_cnt_q == '0);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         data_q       <= '0;
         chan_q       <= 1'b0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= 8'd0;
         p2s_rst_q    <= 1'b1;
         p2s_load_q   <= 1'b0;
         ser_valid_q  <= 1'b0;
         ser_chan_q   <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         chan_q       <= chan_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         p2s_rst_q    <= p2s_rst_d;
         p2s_load_q   <= p2s_load_d;
         ser_valid_q  <= ser_valid_d;
         ser_chan_q   <= ser_chan_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign p2s_rst    = p2s_rst_q;
   assign p2s_load   = p2s_load_q;
   assign p2s_par    = data_q;
   assign ser_valid  = ser_valid_q;
   assign ser_chan   = ser_chan_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_p2s_arb_ctrl.sv
// Bench for p2s_arb_ctrl: two instances (GAP_CYCLES=1 and 0) share the stimulus; each has a
// serialiser model, a cycle-level reference model feeding a frame queue, and a serout monitor.
module tb_p2s_arb_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         v0, v1;
   logic [W-1:0] d0, d1;
   logic [1:0]   r0_rdy, r1_rdy, p_rst, p_load, s_valid, s_chan, f_done, bsy;
   logic [W-1:0] p_par [2];
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   logic         end_chk = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, inst, cyc, act, exp);
      end
   endtask

   for (genvar i = 0; i < 2; i++) begin : gi
      localparam int G = (i == 0) ? 1 : 0;
      logic [W:0]   exp_q[$];
      int           st_q[$];
      logic [W-1:0] sreg = '0;
      logic         sout = 1'b0;
      int           rst_cyc = 0, acc_cyc = -1000, free_cyc = 0;
      int           bidx = 0, st = 0;
      logic         lg = 1'b1, ch = 1'b0, er0 = 1'b0, er1 = 1'b0, end_done = 1'b0;
      logic [W-1:0] acc_data = '0;
      logic [W:0]   cur = '0;

      p2s_arb_ctrl #(.WIDTH(W), .GAP_CYCLES(G)) dut (
         .clk(clk), .rst(rst),
         .req0_valid(v0), .req0_data(d0), .req0_ready(r0_rdy[i]),
         .req1_valid(v1), .req1_data(d1), .req1_ready(r1_rdy[i]),
         .p2s_rst(p_rst[i]), .p2s_load(p_load[i]), .p2s_par(p_par[i]),
         .ser_valid(s_valid[i]), .ser_chan(s_chan[i]),
         .frame_done(f_done[i]), .busy(bsy[i])
      );

      // external MSB-first serialiser: registered serout lags the shift by one edge
      always @(posedge clk) begin
         if (p_rst[i]) begin
            sreg <= '0;
            sout <= 1'b0;
         end else if (p_load[i]) begin
            sreg <= p_par[i];
         end else begin
            sout <= sreg[W-1];
            sreg <= {sreg[W-2:0], 1'b0};
         end
      end

      // reference model: one word per W+2+G cycles, round-robin (or fixed priority)
      always @(negedge clk) begin
         if (!rst) begin
            rst_cyc  = cyc;
            acc_cyc  = -1000;
            free_cyc = cyc + 2;
            lg       = 1'b1;
            exp_q.delete();
            st_q.delete();
            chk("rst_p2s_rst", i, int'(p_rst[i]), 1);
            chk("rst_load", i, int'(p_load[i]), 0);
            chk("rst_par", i, int'(p_par[i]), 0);
            chk("rst_ser_valid", i, int'(s_valid[i]), 0);
            chk("rst_ser_chan", i, int'(s_chan[i]), 0);
            chk("rst_frame_done", i, int'(f_done[i]), 0);
            chk("rst_busy", i, int'(bsy[i]), 0);
            chk("rst_ready", i, int'({r1_rdy[i], r0_rdy[i]}), 0);
         end else begin
            chk("p2s_rst", i, int'(p_rst[i]), int'((cyc - rst_cyc) <= 1));
            er0 = 1'b0;
            er1 = 1'b0;
            if (cyc >= free_cyc && (v0 || v1)) begin
`ifdef P2S_ARB_CTRL_PRIO_EN
               ch = v0 ? 1'b0 : 1'b1;
`else
               ch = (v0 && v1) ? ~lg : (v0 ? 1'b0 : 1'b1);
`endif
               er0      = ~ch;
               er1      = ch;
               lg       = ch;
               acc_cyc  = cyc;
               acc_data = ch ? d1 : d0;
               free_cyc = cyc + W + 2 + G;
               exp_q.push_back({ch, acc_data});
               st_q.push_back(cyc + 3);
            end
            chk("req0_ready", i, int'(r0_rdy[i]), int'(er0));
            chk("req1_ready", i, int'(r1_rdy[i]), int'(er1));
            chk("busy", i, int'(bsy[i]), int'(cyc > acc_cyc && cyc <= acc_cyc + W + 1 + G));
            chk("p2s_load", i, int'(p_load[i]), int'(cyc == acc_cyc + 1));
            if (cyc == acc_cyc + 1) chk("p2s_par", i, int'(p_par[i]), int'(acc_data));
         end
      end

      // monitor: pops one expected frame per ser_valid burst and checks every bit
      always @(negedge clk) begin
         if (!rst) begin
            bidx = 0;
         end else if (s_valid[i]) begin
            if (bidx == 0) begin
               chk("frame_expected", i, int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  st  = st_q.pop_front();
                  chk("frame_start", i, cyc, st);
               end
            end
            chk("ser_chan", i, int'(s_chan[i]), int'(cur[W]));
            chk("serout", i, int'(sout), int'(cur[W-1-bidx]));
            chk("frame_done", i, int'(f_done[i]), int'(bidx == W - 1));
            bidx = (bidx == W - 1) ? 0 : bidx + 1;
         end else begin
            chk("frame_done_idle", i, int'(f_done[i]), 0);
            if (bidx != 0) begin
               chk("frame_short", i, bidx, 0);
               bidx = 0;
            end
         end
         if (end_chk && !end_done) begin
            chk("frames_drained", i, exp_q.size(), 0);
            end_done = 1'b1;
         end
      end
   end

   initial begin
      int   nacc;
      logic found;
      rst = 1'b0;
      v0  = 1'b1;
      v1  = 1'b0;
      d0  = 8'hA5;
      d1  = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      // req0 alone with A5
      repeat (30) @(posedge clk);
      // both contending, fixed data
      #1;
      v0 = 1'b1; v1 = 1'b1; d0 = 8'h0F; d1 = 8'hF0;
      repeat (60) @(posedge clk);
      // req1 alone: FF, then 81 once the GAP=0 instance has taken the first word
      #1;
      v0 = 1'b0; v1 = 1'b1; d1 = 8'hFF;
      nacc = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (r1_rdy[1]) nacc++;
         @(posedge clk);
         #1 d1 = (nacc >= 1) ? 8'h81 : 8'hFF;
      end
      // random valids and data, including drops without acceptance
      for (int n = 0; n < 250; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         @(posedge clk);
         #1;
      end
      // reset during the 4th SHIFT cycle
      v0 = 1'b0; v1 = 1'b0;
      repeat (15) @(posedge clk);
      #1 v0 = 1'b1; d0 = 8'($urandom);
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(negedge clk);
         if (r0_rdy[0]) found = 1'b1;
      end
      chk("accept_seen", 0, int'(found), 1);
      @(posedge clk);
      #1 v0 = 1'b0; d0 = 8'($urandom);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int n = 0; n < 80; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         @(posedge clk);
         #1;
      end
      v0 = 1'b0; v1 = 1'b0;
      repeat (30) @(posedge clk);
      end_chk = 1'b1;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
